// File: rtl/controlador_acesso.sv
// Access sequencer: latches a user code and resource index, checks the
// decoder's permission vector, then issues a timed grant or a deny pulse.
// Repeated denials lead to a timed lockout.
// Ports: clk, reset_n (sync, active-low), req, user[2:0], resource[2:0],
//        perm[6:0] from decoder; user_out[2:0] to decoder, busy, grant,
//        deny, locked, fail_count[1:0].
module controlador_acesso #(
  parameter int GRANT_CYCLES = 8,
  parameter int LOCK_CYCLES  = 16,
  parameter int MAX_FAILS    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [2:0] user,
  input  logic [2:0] resource,
  input  logic [6:0] perm,
  output logic [2:0] user_out,
  output logic       busy,
  output logic       grant,
  output logic       deny,
  output logic       locked,
  output logic [1:0] fail_count
);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CHECK,
    GRANT,
    DENY,
    LOCK
  } state_t;

  localparam logic [7:0] GRANT_LD = 8'(GRANT_CYCLES);
  localparam logic [7:0] LOCK_LD  = 8'(LOCK_CYCLES);
  localparam logic [1:0] FAIL_MAX = 2'(MAX_FAILS);

  state_t     state;
  state_t     state_nx;
  logic [2:0] user_nx;
  logic [2:0] res_q;
  logic [2:0] res_nx;
  logic [7:0] timer;
  logic [7:0] timer_nx;
  logic [1:0] fails_nx;
  logic [7:0] perm_ext;
  logic       hit;

  // Index 7 lands on the padded zero, so an invalid resource never hits.
  assign perm_ext = {1'b0, perm};
  assign hit      = (res_q != 3'd7) && perm_ext[res_q];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      user_out   <= 3'd0;
      res_q      <= 3'd0;
      timer      <= 8'd0;
      fail_count <= 2'd0;
    end else begin
      state      <= state_nx;
      user_out   <= user_nx;
      res_q      <= res_nx;
      timer      <= timer_nx;
      fail_count <= fails_nx;
    end
  end

  always_comb begin
    state_nx = state;
    user_nx  = user_out;
    res_nx   = res_q;
    timer_nx = timer;
    fails_nx = fail_count;
    unique case (state)
      IDLE: begin
        if (req) begin
          user_nx  = user;
          res_nx   = resource;
          state_nx = LATCH;
        end
      end
      LATCH: state_nx = CHECK;
      CHECK: begin
        if (hit) begin
          state_nx = GRANT;
          fails_nx = 2'd0;
          timer_nx = GRANT_LD;
        end else begin
          state_nx = DENY;
          if (fail_count < FAIL_MAX) begin
            fails_nx = fail_count + 2'd1;
          end
        end
      end
      GRANT: begin
        timer_nx = timer - 8'd1;
        if (timer <= 8'd1) begin
          state_nx = IDLE;
        end
      end
      DENY: begin
        if (fail_count >= FAIL_MAX) begin
          state_nx = LOCK;
          timer_nx = LOCK_LD;
        end else begin
          state_nx = IDLE;
        end
      end
      LOCK: begin
        timer_nx = timer - 8'd1;
        if (timer <= 8'd1) begin
          state_nx = IDLE;
          fails_nx = 2'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode straight from the state register: no combinational
  // path from inputs, and the three actions are exclusive by construction.
  assign busy   = (state != IDLE);
  assign grant  = (state == GRANT);
  assign deny   = (state == DENY);
  assign locked = (state == LOCK);

endmodule

// File: tb/tb_controlador_acesso.sv
// Scoreboard bench for controlador_acesso: the driver queues expected
// grant/deny/lock events, an independent monitor measures and checks them.
module tb_controlador_acesso;

  localparam int GC = 8;
  localparam int LC = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic [2:0] user = 3'd0;
  logic [2:0] resource = 3'd0;
  logic [6:0] perm = 7'd0;
  logic [2:0] user_out;
  logic       busy;
  logic       grant;
  logic       deny;
  logic       locked;
  logic [1:0] fail_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int start;
    int len;
    int fc0;
    int fc1;
    int busy1;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  controlador_acesso #(
    .GRANT_CYCLES(GC),
    .LOCK_CYCLES(LC),
    .MAX_FAILS(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .user(user),
    .resource(resource),
    .perm(perm),
    .user_out(user_out),
    .busy(busy),
    .grant(grant),
    .deny(deny),
    .locked(locked),
    .fail_count(fail_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_deny"}, int'(deny), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_fc"}, int'(fail_count), 0);
    chk({tag, "_user_out"}, int'(user_out), 0);
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin : mon
    int   cur;
    int   act;
    int   st;
    int   len;
    int   fc0;
    exp_t e;
    cur = 0;
    st = 0;
    len = 0;
    fc0 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (int'(grant) + int'(deny) + int'(locked) > 1) begin
        errors++;
        $display("FAIL exclusive g=%0b d=%0b l=%0b cyc=%0d",
                 grant, deny, locked, cyc);
      end
      act = grant ? 1 : deny ? 2 : locked ? 3 : 0;
      if (cur != 0 && act != cur) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d start=%0d len=%0d",
                   cur, st, len);
        end else begin
          e = q.pop_front();
          if (e.kind != cur || e.start != st || e.len != len ||
              e.fc0 != fc0 || e.fc1 != int'(fail_count) ||
              e.busy1 != int'(busy)) begin
            errors++;
            $display({"FAIL event got kind=%0d start=%0d len=%0d fc=%0d->%0d",
                      " busy=%0d want kind=%0d start=%0d len=%0d",
                      " fc=%0d->%0d busy=%0d"},
                     cur, st, len, fc0, fail_count, busy,
                     e.kind, e.start, e.len, e.fc0, e.fc1, e.busy1);
          end
        end
      end
      if (act != 0 && act != cur) begin
        st = cyc;
        len = 0;
        fc0 = int'(fail_count);
      end
      if (act != 0) len++;
      cur = act;
    end
  end

  // kind: 0 grant, 1 deny, 2 deny then lockout. fc: expected count after
  // the decision. cut: reset this many cycles into grant/lock (0 = none).
  task automatic txn(input logic [2:0] u, input logic [2:0] r,
                     input logic [6:0] p, input int kind, input int fc,
                     input int cut);
    int   n;
    int   k;
    int   tgt;
    exp_t e;
    @(negedge clk);
    n = cyc;
    req = 1'b1;
    user = u;
    resource = r;
    perm = p;
    if (kind == 0) begin
      e = '{1, n + 3, (cut > 0) ? cut : GC, 0, 0, 0};
      q.push_back(e);
    end else begin
      e = '{2, n + 3, 1, fc, fc, (kind == 2) ? 1 : 0};
      q.push_back(e);
      if (kind == 2) begin
        e = '{3, n + 4, (cut > 0) ? cut : LC, fc, 0, 0};
        q.push_back(e);
      end
    end
    @(negedge clk);
    req = 1'b0;
    user = ~u;
    resource = ~r;
    @(negedge clk);
    chk("user_out", int'(user_out), int'(u));
    if (cut > 0) begin
      tgt = (kind == 0) ? n + 2 + cut : n + 3 + cut;
      while (cyc < tgt) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      rst_chk("midreset");
      reset_n = 1'b1;
    end else if (kind == 2) begin
      while (cyc < n + 6) @(negedge clk);
      req = 1'b1;
      user = 3'b111;
      resource = 3'd0;
      repeat (3) @(negedge clk);
      req = 1'b0;
    end
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_chk("por");
    reset_n = 1'b1;

    txn(3'b100, 3'd4, 7'b1110011, 0, 0, 0);
    txn(3'b000, 3'd2, 7'b0100001, 1, 1, 0);
    txn(3'b000, 3'd2, 7'b0100001, 1, 2, 0);
    txn(3'b000, 3'd2, 7'b0100001, 2, 3, 0);
    chk("fc_after_lock", int'(fail_count), 0);

    txn(3'b000, 3'd2, 7'b0100001, 1, 1, 0);
    txn(3'b000, 3'd2, 7'b0100001, 1, 2, 0);
    txn(3'b001, 3'd3, 7'b0101101, 0, 0, 0);

    txn(3'b010, 3'd7, 7'b1111111, 1, 1, 0);

    txn(3'b100, 3'd4, 7'b1110011, 0, 0, 4);
    txn(3'b100, 3'd4, 7'b1110011, 0, 0, 0);

    txn(3'b011, 3'd0, 7'b1111110, 1, 1, 0);
    txn(3'b011, 3'd0, 7'b1111110, 1, 2, 0);
    txn(3'b011, 3'd0, 7'b1111110, 2, 3, 5);
    chk("fc_after_lock_reset", int'(fail_count), 0);
    txn(3'b001, 3'd3, 7'b0101101, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
